// File: rtl/golden_nonce_uart_tx.sv
// golden_nonce_uart_tx
// Host-link transmit path for golden nonces. Nonces strobed in by the hasher
// core are buffered in a small FIFO. Each one is sent on TxD as four 8N1
// bytes, most significant byte first and LSB first within each byte.
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   nonce_valid   one-cycle strobe qualifying golden_nonce
//   golden_nonce  32-bit nonce to report
//   TxD           registered serial output, idle high
//   busy          registered: FIFO non-empty or a frame in progress
//   fifo_full     registered: FIFO holds FIFO_DEPTH entries
//   overflow      sticky: a nonce was dropped (cleared only by reset)
module golden_nonce_uart_tx #(
  parameter int SPEED_MHZ  = 50,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        nonce_valid,
  input  logic [31:0] golden_nonce,
  output logic        TxD,
  output logic        busy,
  output logic        fifo_full,
  output logic        overflow
);

  localparam int CLKS_PER_BIT = (SPEED_MHZ * 1000000 + BAUD_RATE / 2) / BAUD_RATE;
  localparam int DIV_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [31:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             full_r;
  logic             ovf_r;

  // Transmitter state
  state_t           state_r;
  logic [DIV_W-1:0] div_r;
  logic [2:0]       bit_idx_r;
  logic [1:0]       byte_idx_r;
  logic [31:0]      word_r;
  logic             txd_r;
  logic             busy_r;

  // Combinational controls
  logic       tick_s;
  logic       pop_s;
  logic       push_s;
  logic       drop_s;
  logic       not_empty_s;
  logic [7:0] cur_byte_s;
  logic       tx_bit_s;

  // Bit-period end, FIFO pop/push/drop decisions for this cycle.
  always_comb begin
    tick_s      = (div_r == DIV_LAST);
    not_empty_s = (count_r != CNT_ZERO);
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: pop_s = not_empty_s;
      // The last stop bit of a word chains straight into the next queued word.
      ST_STOP: pop_s = tick_s && (byte_idx_r == 2'd3) && not_empty_s;
      default: pop_s = 1'b0;
    endcase
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    push_s = nonce_valid && ((count_r != CNT_FULL) || pop_s);
    drop_s = nonce_valid && !push_s;
  end

  // Next FIFO occupancy from this cycle's push/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Select the byte being sent (byte 0 is the most significant).
  always_comb begin
    cur_byte_s = 8'h00;
    case (byte_idx_r)
      2'd0:    cur_byte_s = word_r[31:24];
      2'd1:    cur_byte_s = word_r[23:16];
      2'd2:    cur_byte_s = word_r[15:8];
      default: cur_byte_s = word_r[7:0];
    endcase
  end

  // Line level implied by the current state; registered into TxD below.
  always_comb begin
    tx_bit_s = 1'b1;
    case (state_r)
      ST_START: tx_bit_s = 1'b0;
      ST_DATA:  tx_bit_s = cur_byte_s[bit_idx_r];
      default:  tx_bit_s = 1'b1;
    endcase
  end

  // Nonce FIFO: storage, pointers, occupancy, full flag and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= golden_nonce;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r        <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_FULL);
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  // Transmit FSM with baud divider and registered TxD/busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      div_r      <= DIV_ZERO;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 2'd0;
      word_r     <= 32'h0000_0000;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      // Outputs follow the state one cycle later, so every period keeps its length.
      txd_r  <= tx_bit_s;
      busy_r <= (state_r != ST_IDLE) || not_empty_s;
      case (state_r)
        ST_IDLE: begin
          div_r <= DIV_ZERO;
          if (pop_s) begin
            word_r     <= mem_r[rd_ptr_r];
            byte_idx_r <= 2'd0;
            state_r    <= ST_START;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_START: begin
          if (tick_s) begin
            div_r     <= DIV_ZERO;
            bit_idx_r <= 3'd0;
            state_r   <= ST_DATA;
          end else begin
            div_r     <= div_r + DIV_W'(1);
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            div_r <= DIV_ZERO;
            if (bit_idx_r == 3'd7) begin
              state_r   <= ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            div_r <= DIV_ZERO;
            if (byte_idx_r != 2'd3) begin
              byte_idx_r <= byte_idx_r + 2'd1;
              state_r    <= ST_START;
            end else if (pop_s) begin
              word_r     <= mem_r[rd_ptr_r];
              byte_idx_r <= 2'd0;
              state_r    <= ST_START;
            end else begin
              state_r    <= ST_IDLE;
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        default: begin
          div_r   <= DIV_ZERO;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign TxD       = txd_r;
  assign busy      = busy_r;
  assign fifo_full = full_r;
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Bench for golden_nonce_uart_tx: a fast instance (4 clocks per bit) for the
// functional scenarios and a default-parameter instance for the baud check.
module tb_golden_nonce_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 40 * CPB;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        nv_a, nv_b;
  logic [31:0] gn_a, gn_b;
  logic        txd_a, busy_a, full_a, ovf_a;
  logic        txd_b, busy_b, full_b, ovf_b;

  always #5 clk = ~clk;

  golden_nonce_uart_tx #(.SPEED_MHZ(1), .BAUD_RATE(250000), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .reset_n(reset_n), .nonce_valid(nv_a), .golden_nonce(gn_a),
    .TxD(txd_a), .busy(busy_a), .fifo_full(full_a), .overflow(ovf_a)
  );

  golden_nonce_uart_tx dut_b (
    .clk(clk), .reset_n(reset_n), .nonce_valid(nv_b), .golden_nonce(gn_b),
    .TxD(txd_b), .busy(busy_b), .fifo_full(full_b), .overflow(ovf_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: the transmitter takes a new word at most once
  // every FRAME cycles; the queue holds DEPTH words.
  longint      cyc = 0;
  longint      last_pop = -1000;
  int          m_cnt = 0;
  bit          m_pop, m_push;
  bit          exp_ovf = 1'b0, exp_full = 1'b0, exp_busy = 1'b0;
  logic [7:0]  exp_bytes[$];
  logic [7:0]  got_bytes[$];
  longint      start_times[$];
  bit          chk_on = 1'b0;
  bit          mon_abort = 1'b0;
  logic        mon_sb, mon_stop;
  logic [7:0]  mon_d;

  initial begin : model
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_cnt = 0; last_pop = -1000; exp_ovf = 1'b0; exp_full = 1'b0; exp_busy = 1'b0;
      end else begin
        cyc = cyc + 1;
        m_pop    = (m_cnt > 0) && (cyc >= last_pop + FRAME);
        exp_busy = (m_cnt > 0) || ((cyc > last_pop) && (cyc <= last_pop + FRAME));
        m_push   = nv_a && ((m_cnt < DEPTH) || m_pop);
        if (nv_a && !m_push) exp_ovf = 1'b1;
        if (m_pop) begin
          m_cnt = m_cnt - 1;
          last_pop = cyc;
        end
        if (m_push) begin
          m_cnt = m_cnt + 1;
          exp_bytes.push_back(gn_a[31:24]);
          exp_bytes.push_back(gn_a[23:16]);
          exp_bytes.push_back(gn_a[15:8]);
          exp_bytes.push_back(gn_a[7:0]);
        end
        exp_full = (m_cnt == DEPTH);
      end
    end
  end

  initial begin : cycle_checker
    forever begin
      @(negedge clk);
      if (chk_on && reset_n === 1'b1) begin
        n_tests = n_tests + 3;
        if (full_a !== exp_full) begin
          n_fail++; $display("FAIL full_track t=%0t got=%b exp=%b", $time, full_a, exp_full);
        end
        if (ovf_a !== exp_ovf) begin
          n_fail++; $display("FAIL ovf_track t=%0t got=%b exp=%b", $time, ovf_a, exp_ovf);
        end
        if (busy_a !== exp_busy) begin
          n_fail++; $display("FAIL busy_track t=%0t got=%b exp=%b", $time, busy_a, exp_busy);
        end
      end
    end
  end

  initial begin : abort_on_reset
    forever begin
      @(negedge reset_n);
      mon_abort = 1'b1;
    end
  end

  // UART decoder: samples near mid-bit, discards frames cut by reset.
  initial begin : monitor
    forever begin
      @(negedge txd_a);
      if (reset_n === 1'b1) begin
        mon_abort = 1'b0;
        start_times.push_back($time);
        repeat (2) @(negedge clk);
        mon_sb = txd_a;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_d[i] = txd_a;
        end
        repeat (CPB) @(negedge clk);
        mon_stop = txd_a;
        if (!mon_abort) begin
          n_tests = n_tests + 2;
          if (mon_sb !== 1'b0) begin
            n_fail++; $display("FAIL start_bit got=%b exp=0", mon_sb);
          end
          if (mon_stop !== 1'b1) begin
            n_fail++; $display("FAIL stop_bit got=%b exp=1", mon_stop);
          end
          got_bytes.push_back(mon_d);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    exp_bytes.delete(); got_bytes.delete(); start_times.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic strobe_a(input logic [31:0] w);
    @(negedge clk);
    nv_a = 1'b1; gn_a = w;
    @(negedge clk);
    nv_a = 1'b0;
  endtask

  // Wait until the line is idle and everything queued has been decoded.
  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy_a === 1'b0 && m_cnt == 0 && got_bytes.size() >= exp_bytes.size()) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    reset_n = 1'b0; nv_a = 1'b0; nv_b = 1'b0; gn_a = 32'h0; gn_b = 32'h0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({txd_a, busy_a, full_a, ovf_a, txd_b} !== 5'b10001) begin
      n_fail++; $display("FAIL reset_values got=%b exp=10001", {txd_a, busy_a, full_a, ovf_a, txd_b});
    end
    reset_n = 1'b1;
    chk_on = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (txd_a !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL reset_idle_line got=%0d low samples exp=0", bad);
    end
  endtask

  task automatic test_single();
    logic [7:0] want [4];
    bit ok;
    want = '{8'h1a, 8'hfd, 8'ha0, 8'h99};
    got_bytes.delete(); exp_bytes.delete(); start_times.delete();
    strobe_a(32'h1afda099);             // now at N + half cycle
    n_tests++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL single_busy_N got=%b exp=0", busy_a); end
    @(negedge clk);                     // N+1
    n_tests += 2;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy_N1 got=%b exp=1", busy_a); end
    if (txd_a !== 1'b1) begin n_fail++; $display("FAIL single_txd_N1 got=%b exp=1", txd_a); end
    @(negedge clk);                     // N+2
    n_tests++;
    if (txd_a !== 1'b0) begin n_fail++; $display("FAIL single_txd_N2 got=%b exp=0", txd_a); end
    repeat (FRAME - 1) @(negedge clk);
    n_tests++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy_before_end got=%b exp=1", busy_a); end
    @(negedge clk);
    n_tests++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got=%b exp=0", busy_a); end
    wait_drain(100, ok);
    n_tests++;
    if (!ok || got_bytes.size() != 4) begin
      n_fail++; $display("FAIL single_count got=%0d bytes exp=4", got_bytes.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (got_bytes[i] !== want[i]) begin
          n_fail++; $display("FAIL single_byte%0d got=%h exp=%h", i, got_bytes[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_two();
    logic [7:0] want [8];
    bit ok;
    want = '{8'h30, 8'hd9, 8'hdb, 8'h77, 8'h00, 8'h01, 8'h87, 8'h90};
    got_bytes.delete(); exp_bytes.delete(); start_times.delete();
    @(negedge clk); nv_a = 1'b1; gn_a = 32'h30d9db77;
    @(negedge clk); gn_a = 32'h00018790;
    @(negedge clk); nv_a = 1'b0;
    wait_drain(3 * FRAME, ok);
    n_tests++;
    if (!ok || got_bytes.size() != 8) begin
      n_fail++; $display("FAIL two_count got=%0d bytes exp=8", got_bytes.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (got_bytes[i] !== want[i]) begin
          n_fail++; $display("FAIL two_byte%0d got=%h exp=%h", i, got_bytes[i], want[i]);
        end
      end
      for (int i = 1; i < 8; i++) begin
        n_tests++;
        if (start_times[i] - start_times[i-1] != 64'd400) begin
          n_fail++; $display("FAIL two_gap%0d got=%0d exp=400", i, start_times[i] - start_times[i-1]);
        end
      end
    end
    n_tests++;
    if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL two_overflow got=%b exp=0", ovf_a); end
  endtask

  task automatic test_random();
    bit ok;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      strobe_a($urandom);
      repeat ($urandom_range(0, 200)) @(negedge clk);
    end
    wait_drain(16 * FRAME, ok);
    n_tests++;
    if (!ok || got_bytes.size() != exp_bytes.size()) begin
      n_fail++; $display("FAIL random_count got=%0d exp=%0d", got_bytes.size(), exp_bytes.size());
    end else begin
      for (int i = 0; i < exp_bytes.size(); i++) begin
        n_tests++;
        if (got_bytes[i] !== exp_bytes[i]) begin
          n_fail++; $display("FAIL random_byte%0d got=%h exp=%h", i, got_bytes[i], exp_bytes[i]);
        end
      end
    end
  endtask

  task automatic test_full_push_pop();
    bit ok, hit;
    logic [31:0] w_last;
    logic [7:0]  want [4];
    w_last = 32'hc0ffee42;
    want = '{8'hc0, 8'hff, 8'hee, 8'h42};
    do_reset();
    @(negedge clk); nv_a = 1'b1; gn_a = $urandom;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk); gn_a = $urandom;
    end
    @(negedge clk); nv_a = 1'b0;
    n_tests++;
    if (full_a !== 1'b1) begin n_fail++; $display("FAIL fpp_full_before got=%b exp=1", full_a); end
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (cyc == last_pop + FRAME - 1) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!hit) begin n_fail++; $display("FAIL fpp_sync got=timeout exp=chain_pop_edge"); end
    nv_a = 1'b1; gn_a = w_last;
    @(negedge clk); nv_a = 1'b0;
    n_tests += 2;
    if (full_a !== 1'b1) begin n_fail++; $display("FAIL fpp_full_after got=%b exp=1", full_a); end
    if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow got=%b exp=0", ovf_a); end
    wait_drain(8 * FRAME, ok);
    n_tests++;
    if (!ok || got_bytes.size() != 24 || exp_bytes.size() != 24) begin
      n_fail++; $display("FAIL fpp_count got=%0d exp=24", got_bytes.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        n_tests++;
        if (got_bytes[i] !== exp_bytes[i]) begin
          n_fail++; $display("FAIL fpp_byte%0d got=%h exp=%h", i, got_bytes[i], exp_bytes[i]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (got_bytes[20 + i] !== want[i]) begin
          n_fail++; $display("FAIL fpp_last_word%0d got=%h exp=%h", i, got_bytes[20 + i], want[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    @(negedge clk); nv_a = 1'b1; gn_a = 32'd1;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      if (k == 6) begin
        n_tests++;
        if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%b exp=0", ovf_a); end
      end
      gn_a = k;
    end
    @(negedge clk); nv_a = 1'b0;
    n_tests++;
    if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", ovf_a); end
    wait_drain(7 * FRAME, ok);
    n_tests += 2;
    if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", ovf_a); end
    if (!ok || got_bytes.size() != 20) begin
      n_fail++; $display("FAIL ovf_count got=%0d exp=20", got_bytes.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        n_tests++;
        if (got_bytes[i] !== (((i % 4) == 3) ? 8'(i / 4 + 1) : 8'h00)) begin
          n_fail++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, got_bytes[i],
                             (((i % 4) == 3) ? 8'(i / 4 + 1) : 8'h00));
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit hit;
    int bad;
    do_reset();
    @(negedge clk); nv_a = 1'b1; gn_a = 32'h0000_0000;
    @(negedge clk); gn_a = $urandom;
    @(negedge clk); gn_a = $urandom;
    @(negedge clk); nv_a = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (cyc == last_pop + 50) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    n_tests += 2;
    if (!hit) begin n_fail++; $display("FAIL rst_sync got=timeout exp=byte1_data"); end
    if (txd_a !== 1'b0) begin n_fail++; $display("FAIL rst_pre_txd got=%b exp=0", txd_a); end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({txd_a, busy_a, full_a, ovf_a} !== 4'b1000) begin
      n_fail++; $display("FAIL rst_async got=%b exp=1000", {txd_a, busy_a, full_a, ovf_a});
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    got_bytes.delete(); exp_bytes.delete();
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    n_tests += 2;
    if (bad != 0) begin n_fail++; $display("FAIL rst_quiet got=%0d active samples exp=0", bad); end
    if (got_bytes.size() != 0) begin n_fail++; $display("FAIL rst_no_bytes got=%0d exp=0", got_bytes.size()); end
  endtask

  task automatic test_default_baud();
    int width;
    bit seen;
    @(negedge clk); nv_b = 1'b1; gn_b = 32'h0100_0000;
    @(negedge clk); nv_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (txd_b === 1'b0) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    width = 0;
    if (seen) begin
      for (int i = 0; i < 1000; i++) begin
        if (txd_b !== 1'b0) break;
        width++;
        @(negedge clk);
      end
    end
    n_tests++;
    if (width != 434) begin
      n_fail++; $display("FAIL default_start_width got=%0d exp=434", width);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_random();
    test_full_push_pop();
    test_overflow();
    test_reset_mid_frame();
    test_default_baud();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
